// File: rtl/bus_gen_arbiter_pkg.sv
// bus_pkg: shared types and helpers for the shared-bus generator/arbiter.
//   state_t  - per-bus transfer FSM state (IDLE -> POP -> PUSH)
//   ID_W     - width of the destination ID field at the top of each packet
//   get_dst  - extracts the destination ID from a packet of a given width
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      PUSH = 2'd2
   } state_t;

   localparam int unsigned ID_W      = 8;
   // Widest packet get_dst accepts; callers zero-extend into this width.
   localparam int unsigned PKT_MAX_W = 256;

   // Destination ID = top ID_W bits of a pkt_w-bit packet.
   function automatic logic [ID_W-1:0] get_dst(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned          pkt_w);
      return ID_W'(pkt >> (pkt_w - ID_W));
   endfunction

endpackage

// File: rtl/bus_gen_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin arbiter over N requesters.
//   clk, reset  - clock, synchronous active-high reset
//   req         - request vector
//   advance     - commit the current grant as the last-granted index
//   grant_c     - one-hot grant (combinational)
//   idx_c       - index of the granted requester (combinational)
//   any_c       - at least one request is present (combinational)
// The search starts strictly after the last granted index and wraps.
module rr_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant_c,
   output logic [IW-1:0] idx_c,
   output logic          any_c
);

   logic [IW-1:0] last_q;
   logic [IW-1:0] cand;

   // Rotating priority search: offsets 1..N from the last grant, N itself wraps to last.
   always_comb begin
      grant_c = '0;
      idx_c   = '0;
      any_c   = 1'b0;
      cand    = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = IW'((32'(last_q) + i) % N);
         if (!any_c && req[cand]) begin
            any_c = 1'b1;
            idx_c = cand;
         end
      end
      if (any_c) grant_c[idx_c] = 1'b1;
   end

   // Reset to N-1 so the first search begins at requester 0.
   always_ff @(posedge clk) begin
      if (reset)        last_q <= IW'(N - 1);
      else if (advance) last_q <= idx_c;
   end

endmodule

// File: rtl/bus_gen_arbiter.sv
// bus_gen_arbiter: shared-bus generator and arbiter.
// For each of `bits` independent buses, grants one pending device at a time
// (round-robin), pops its head packet, then pushes it to the addressed device
// or, for the broadcast ID, to every device except the source.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   pndng      - [bits][drvrs] device FIFO non-empty
//   D_pop      - [bits][drvrs][pckg_sz] device FIFO head word
//   pop        - [bits][drvrs] one-cycle read strobe (registered)
//   push       - [bits][drvrs] one-cycle write strobe (registered)
//   D_push     - [bits][drvrs][pckg_sz] push data, same word to all devices on a bus (registered)
// Build option: define BCAST_SELF_EN to also deliver broadcasts back to the source.
module bus_gen_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned bits      = 1,
   parameter int unsigned drvrs     = 4,
   parameter int unsigned pckg_sz   = 16,
   parameter logic [7:0]  broadcast = 8'hFF
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [bits-1:0][drvrs-1:0]            pndng,
   output logic [bits-1:0][drvrs-1:0]            push,
   output logic [bits-1:0][drvrs-1:0]            pop,
   input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
   output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

   localparam int unsigned IW = (drvrs > 1) ? $clog2(drvrs) : 1;

`ifdef BCAST_SELF_EN
   localparam bit BCAST_SELF = 1'b1;
`else
   localparam bit BCAST_SELF = 1'b0;
`endif

   for (genvar b = 0; b < bits; b++) begin : g_bus
      state_t             state_q, state_d;
      logic [IW-1:0]      src_q, src_d;
      logic [pckg_sz-1:0] pkt_q, pkt_d;
      logic [pckg_sz-1:0] dpush_q, dpush_d;
      logic [drvrs-1:0]   pop_q, pop_d;
      logic [drvrs-1:0]   push_q, push_d;
      logic [drvrs-1:0]   grant_c;
      logic [IW-1:0]      idx_c;
      logic               any_c;
      logic               advance_c;
      logic [ID_W-1:0]    dst_c;
      logic [drvrs-1:0]   route_c;

      assign advance_c = (state_q == IDLE) && any_c;

      rr_arbiter #(.N(drvrs), .IW(IW)) u_arb (
         .clk     (clk),
         .reset   (reset),
         .req     (pndng[b]),
         .advance (advance_c),
         .grant_c (grant_c),
         .idx_c   (idx_c),
         .any_c   (any_c)
      );

      // Destination decode of the latched packet; unknown IDs route nowhere.
      always_comb begin
         route_c = '0;
         dst_c   = get_dst(PKT_MAX_W'(pkt_q), pckg_sz);
         for (int unsigned j = 0; j < drvrs; j++) begin
            if (32'(dst_c) < drvrs)      route_c[j] = (32'(dst_c) == j);
            else if (dst_c == broadcast) route_c[j] = BCAST_SELF || (IW'(j) != src_q);
         end
      end

      // Transfer FSM next-state and next-output logic.
      always_comb begin
         state_d = state_q;
         src_d   = src_q;
         pkt_d   = pkt_q;
         dpush_d = dpush_q;
         pop_d   = '0;
         push_d  = '0;
         case (state_q)
            IDLE: begin
               if (any_c) begin
                  pkt_d   = D_pop[b][idx_c];
                  src_d   = idx_c;
                  pop_d   = grant_c;
                  state_d = POP;
               end
            end
            POP: begin
               push_d = route_c;
               // Dropped packets leave the previous D_push word in place.
               if (|route_c) dpush_d = pkt_q;
               state_d = PUSH;
            end
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // State and registered outputs.
      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            pkt_q   <= '0;
            dpush_q <= '0;
            pop_q   <= '0;
            push_q  <= '0;
         end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pkt_q   <= pkt_d;
            dpush_q <= dpush_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
         end
      end

      assign pop[b]  = pop_q;
      assign push[b] = push_q;
      for (genvar j = 0; j < drvrs; j++) begin : g_dpush
         assign D_push[b][j] = dpush_q;
      end
   end

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Self-checking bench for bus_gen_arbiter (bits=1, drvrs=4, pckg_sz=16, broadcast=8'hFF).
// Device FIFOs are modelled with queues; pops are serviced on the falling edge.
module tb_bus_gen_arbiter;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [0:0][3:0]        pndng;
   logic [0:0][3:0]        push;
   logic [0:0][3:0]        pop;
   logic [0:0][3:0][15:0]  D_pop;
   logic [0:0][3:0][15:0]  D_push;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [15:0] fq [4][$];
   int          grant_idx [$];
   int          grant_cyc [$];
   logic [3:0]  push_mask_log [$];
   logic [15:0] push_data_log [$];

   always #5 clk = ~clk;

   bus_gen_arbiter #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
      .clk    (clk),
      .reset  (reset),
      .pndng  (pndng),
      .push   (push),
      .pop    (pop),
      .D_pop  (D_pop),
      .D_push (D_push)
   );

   task automatic refresh();
      for (int i = 0; i < 4; i++) begin
         pndng[0][i] = (fq[i].size() > 0);
         D_pop[0][i] = (fq[i].size() > 0) ? fq[i][0] : 16'h0000;
      end
   endtask

   task automatic enqueue(input int d, input logic [15:0] w);
      fq[d].push_back(w);
      refresh();
   endtask

   // Advance to the next falling edge, log strobes, service device FIFO pops.
   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (pop[0][i]) begin
            grant_idx.push_back(i);
            grant_cyc.push_back(cyc);
            if (fq[i].size() > 0) void'(fq[i].pop_front());
         end
      end
      if (push[0] != 4'b0000) begin
         push_mask_log.push_back(push[0]);
         push_data_log.push_back(D_push[0][0]);
      end
      refresh();
   endtask

   task automatic clear_logs();
      grant_idx.delete();
      grant_cyc.delete();
      push_mask_log.delete();
      push_data_log.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      refresh();
      tick();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_checks++;
         if (push !== 4'b0000 || pop !== 4'b0000 || D_push !== '0) begin
            n_fail++;
            $display("FAIL reset_idle cyc%0d: push=%b pop=%b D_push=%h, want all zero",
                     c, push, pop, D_push);
         end
      end
   endtask

   task automatic test_single();
      enqueue(1, 16'h02AB);
      tick();
      n_checks++;
      if (pop[0] !== 4'b0010 || push[0] !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_pop: pop=%b push=%b, want pop=0010 push=0000", pop[0], push[0]);
      end
      tick();
      n_checks++;
      if (pop[0] !== 4'b0000 || push[0] !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_push: pop=%b push=%b, want pop=0000 push=0100", pop[0], push[0]);
      end
      n_checks++;
      if (D_push[0][2] !== 16'h02AB || D_push[0][0] !== 16'h02AB) begin
         n_fail++;
         $display("FAIL single_data: D_push[2]=%h D_push[0]=%h, want 02ab", D_push[0][2], D_push[0][0]);
      end
      tick();
      n_checks++;
      if (push[0] !== 4'b0000 || pop[0] !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_end: push=%b pop=%b, want 0000/0000", push[0], pop[0]);
      end
   endtask

   task automatic test_round_robin();
      int          exp_idx  [4];
      logic [3:0]  exp_mask [4];
      logic [15:0] exp_data [4];
      int          budget;
      exp_idx  = '{0, 3, 0, 3};
      exp_mask = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
      exp_data = '{16'h0100, 16'h0230, 16'h0101, 16'h0231};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_logs();
      enqueue(0, 16'h0100);
      enqueue(0, 16'h0101);
      enqueue(3, 16'h0230);
      enqueue(3, 16'h0231);
      budget = 0;
      while (push_mask_log.size() < 4 && budget < 40) begin
         tick();
         budget++;
      end
      n_checks++;
      if (push_mask_log.size() < 4 || grant_idx.size() != 4) begin
         n_fail++;
         $display("FAIL rr_count: grants=%0d pushes=%0d, want 4/4",
                  grant_idx.size(), push_mask_log.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (grant_idx[k] != exp_idx[k] || push_mask_log[k] !== exp_mask[k] ||
                push_data_log[k] !== exp_data[k]) begin
               n_fail++;
               $display("FAIL rr_xfer%0d: grant=%0d mask=%b data=%h, want grant=%0d mask=%b data=%h",
                        k, grant_idx[k], push_mask_log[k], push_data_log[k],
                        exp_idx[k], exp_mask[k], exp_data[k]);
            end
            if (k > 0) begin
               n_checks++;
               if (grant_cyc[k] - grant_cyc[k-1] != 3) begin
                  n_fail++;
                  $display("FAIL rr_spacing%0d: gap=%0d, want 3", k, grant_cyc[k] - grant_cyc[k-1]);
               end
            end
         end
      end
      tick();
   endtask

   task automatic test_broadcast();
      logic [3:0] exp_mask;
`ifdef BCAST_SELF_EN
      exp_mask = 4'b1111;
`else
      exp_mask = 4'b1011;
`endif
      enqueue(2, 16'hFF5A);
      tick();
      n_checks++;
      if (pop[0] !== 4'b0100) begin
         n_fail++;
         $display("FAIL bcast_pop: pop=%b, want 0100", pop[0]);
      end
      tick();
      n_checks++;
      if (push[0] !== exp_mask || D_push[0][0] !== 16'hFF5A || D_push[0][3] !== 16'hFF5A) begin
         n_fail++;
         $display("FAIL bcast_push: push=%b data=%h, want push=%b data=ff5a",
                  push[0], D_push[0][0], exp_mask);
      end
      tick();
      n_checks++;
      if (push[0] !== 4'b0000) begin
         n_fail++;
         $display("FAIL bcast_end: push=%b, want 0000", push[0]);
      end
   endtask

   task automatic test_drop();
      enqueue(0, 16'h0711);
      tick();
      n_checks++;
      if (pop[0] !== 4'b0001 || push[0] !== 4'b0000) begin
         n_fail++;
         $display("FAIL drop_pop: pop=%b push=%b, want 0001/0000", pop[0], push[0]);
      end
      tick();
      n_checks++;
      if (push[0] !== 4'b0000 || pop[0] !== 4'b0000) begin
         n_fail++;
         $display("FAIL drop_nopush: push=%b pop=%b, want 0000/0000", push[0], pop[0]);
      end
      n_checks++;
      if (D_push[0][0] !== 16'hFF5A) begin
         n_fail++;
         $display("FAIL drop_hold: D_push=%h, want ff5a (previous word kept)", D_push[0][0]);
      end
      tick();
      n_checks++;
      if (push[0] !== 4'b0000) begin
         n_fail++;
         $display("FAIL drop_idle: push=%b, want 0000", push[0]);
      end
      // A new request now must be taken at the very next edge, proving the FSM is idle.
      enqueue(3, 16'h0055);
      tick();
      n_checks++;
      if (pop[0] !== 4'b1000) begin
         n_fail++;
         $display("FAIL drop_next_pop: pop=%b, want 1000", pop[0]);
      end
      tick();
      n_checks++;
      if (push[0] !== 4'b0001 || D_push[0][0] !== 16'h0055) begin
         n_fail++;
         $display("FAIL drop_next_push: push=%b data=%h, want 0001/0055", push[0], D_push[0][0]);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic saw_push;
      enqueue(1, 16'h0133);
      tick();
      n_checks++;
      if (pop[0] !== 4'b0010) begin
         n_fail++;
         $display("FAIL rmid_pop: pop=%b, want 0010", pop[0]);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if (push !== 4'b0000 || pop !== 4'b0000 || D_push !== '0) begin
         n_fail++;
         $display("FAIL rmid_clear: push=%b pop=%b D_push=%h, want all zero", push, pop, D_push);
      end
      reset = 1'b0;
      saw_push = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (push[0] !== 4'b0000) saw_push = 1'b1;
      end
      n_checks++;
      if (saw_push) begin
         n_fail++;
         $display("FAIL rmid_nopush: push seen after reset abort, want none");
      end
   endtask

   initial begin
      pndng  = '0;
      D_pop  = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_broadcast();
      test_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
